// File: rtl/display_scan_pkg.sv
// Shared constants for the counter seven-segment display instances.
// Holds the digit width, the anode polarity and the default scan timing.
package display_scan_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam logic ANODE_OFF = 1'b1;
    localparam logic ANODE_ON  = 1'b0;

    localparam int DEF_TICK_DIV     = 50000;
    localparam int DEF_BLANK_CYCLES = 16;

endpackage

// File: rtl/display_scan_if.sv
// Display scan bus: the value to show, load and blanking controls in; the anode select and digit value out.
// The master drives the value side and the slave (the scan controller) drives the display side.
interface display_scan_if
    import display_scan_pkg::*;
#(
    parameter int N_DIGITS = 4
) ();

    logic [DIGIT_W*N_DIGITS-1:0] value;
    logic                        load;
    logic                        lz_blank;
    digit_t                      dig_val;
    logic [N_DIGITS-1:0]         an;
    logic                        slot_start;

    modport master (
        output value, load, lz_blank,
        input  dig_val, an, slot_start
    );

    modport slave (
        input  value, load, lz_blank,
        output dig_val, an, slot_start
    );

endinterface

// File: rtl/display_scan_tick_gen.sv
// Slot prescaler: counts 0..TICK_DIV-1 and flags the wrap cycle, the first cycle and the blank window.
// All flags decode the registered count, so they are valid in the same cycle as the count; there is no backpressure.
module display_scan_tick_gen
    import display_scan_pkg::*;
#(
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic clk,
    input  logic rst,
    output logic wrap_o,
    output logic first_o,
    output logic in_blank_o
);

    localparam int PRESC_W = $clog2(TICK_DIV);

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;

    always_comb begin
        wrap_o     = (presc_q == PRESC_W'(TICK_DIV - 1));
        first_o    = (presc_q == '0);
        in_blank_o = (presc_q < PRESC_W'(BLANK_CYCLES));
        presc_d    = wrap_o ? '0 : presc_q + PRESC_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/display_scan.sv
// Multiplexed seven-segment scan controller: snapshots a packed hex value and walks a one-hot-low anode across the digits.
// All outputs are registered one cycle behind the scan state; there is no backpressure, and a load is always accepted.
module display_scan
    import display_scan_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    display_scan_if.slave   bus
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int VAL_W = DIGIT_W * N_DIGITS;

    logic wrap;
    logic slot_first;
    logic in_blank;

    display_scan_tick_gen #(
        .TICK_DIV     (TICK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_tick_gen (
        .clk        (clk),
        .rst        (rst),
        .wrap_o     (wrap),
        .first_o    (slot_first),
        .in_blank_o (in_blank)
    );

    logic [VAL_W-1:0]    shadow_q, shadow_d;
    logic [VAL_W-1:0]    active_q, active_d;
    logic                pending_q, pending_d;
    logic [IDX_W-1:0]    index_q, index_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    digit_t              dig_val_q, dig_val_d;
    logic                slot_start_q, slot_start_d;

    logic [N_DIGITS-1:0] lz_dark;
    logic                zero_above;

    // active only moves on a slot boundary, so a digit can never change mid-slot
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        index_d   = index_q;
        if (bus.load) begin
            shadow_d = bus.value;
        end
        if (wrap) begin
            index_d = (index_q == IDX_W'(N_DIGITS - 1)) ? '0 : index_q + IDX_W'(1);
            if (bus.load) begin
                active_d  = bus.value;
                pending_d = 1'b0;
            end else if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end else if (bus.load) begin
            pending_d = 1'b1;
        end
    end

    // Digit i is dark when it and every digit above it are zero; digit 0 always shows
    always_comb begin
        lz_dark    = '0;
        zero_above = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (active_q[DIGIT_W*i +: DIGIT_W] == '0);
            lz_dark[i] = zero_above;
        end
    end

    always_comb begin
        dig_val_d    = '0;
        an_d         = {N_DIGITS{ANODE_OFF}};
        slot_start_d = slot_first;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (index_q == IDX_W'(i)) begin
                dig_val_d = active_q[DIGIT_W*i +: DIGIT_W];
                if (!in_blank && !(bus.lz_blank && lz_dark[i])) begin
                    an_d[i] = ANODE_ON;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            index_q      <= '0;
            an_q         <= {N_DIGITS{ANODE_OFF}};
            dig_val_q    <= '0;
            slot_start_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            index_q      <= index_d;
            an_q         <= an_d;
            dig_val_q    <= dig_val_d;
            slot_start_q <= slot_start_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.dig_val    = dig_val_q;
    assign bus.slot_start = slot_start_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with 4 digits, 8-cycle slots and a 2-cycle blank window.
// Edge e after reset release: output slot s spans edges 8s+1..8s+8 and shows digit s mod 4.
module tb_display_scan;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   e        = 0;

    display_scan_if #(.N_DIGITS(4)) bus ();

    display_scan #(
        .N_DIGITS     (4),
        .TICK_DIV     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Two lit anodes would mean ghosting on the display
    always @(negedge clk) begin
        checks++;
        assert (!$isunknown(bus.an) && $countones(~bus.an) <= 1) else begin
            failures++;
            $error("FAIL an_onehot observed=%b expected=at_most_one_zero", bus.an);
        end
    end

    task automatic edge_step();
        @(posedge clk);
        e++;
        @(negedge clk);
    endtask

    // Checks one whole output slot; optional loads are driven after the sample at positions pa/pb
    task automatic check_slot(input string tag, input int idx, input logic [3:0] dig, input logic lit,
                              input int pa, input logic [15:0] va, input int pb, input logic [15:0] vb);
        logic [3:0] exp_an;
        for (int p = 0; p < 8; p++) begin
            edge_step();
            exp_an = (lit && p >= 2) ? ~(4'b0001 << idx) : 4'b1111;
            chk($sformatf("%s_p%0d_an", tag, p), 16'(bus.an), 16'(exp_an));
            chk($sformatf("%s_p%0d_dig", tag, p), 16'(bus.dig_val), 16'(dig));
            chk($sformatf("%s_p%0d_ss", tag, p), 16'(bus.slot_start), (p == 0) ? 16'd1 : 16'd0);
            bus.load = 1'b0;
            if (p == pa) begin
                bus.value = va;
                bus.load  = 1'b1;
            end
            if (p == pb) begin
                bus.value = vb;
                bus.load  = 1'b1;
            end
        end
    endtask

    task automatic slot(input string tag, input int idx, input logic [3:0] dig, input logic lit);
        check_slot(tag, idx, dig, lit, -1, 16'h0, -1, 16'h0);
    endtask

    initial begin
        bus.value    = 16'h0;
        bus.load     = 1'b0;
        bus.lz_blank = 1'b0;
        rst          = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_an", 16'(bus.an), 16'h000F);
        chk("rst_dig", 16'(bus.dig_val), 16'h0);
        chk("rst_ss", 16'(bus.slot_start), 16'h0);

        rst = 1'b0;
        e   = 0;

        // Free-running scan of the reset value
        slot("s0", 0, 4'h0, 1'b1);
        slot("s1", 1, 4'h0, 1'b1);
        slot("s2", 2, 4'h0, 1'b1);
        slot("s3", 3, 4'h0, 1'b1);
        slot("s4", 0, 4'h0, 1'b1);
        slot("s5", 1, 4'h0, 1'b1);

        // Mid-slot load waits for the next boundary
        check_slot("s6", 2, 4'h0, 1'b1, 2, 16'h1A3F, -1, 16'h0);
        slot("s7", 3, 4'h1, 1'b1);
        slot("s8", 0, 4'hF, 1'b1);
        slot("s9", 1, 4'h3, 1'b1);
        slot("s10", 2, 4'hA, 1'b1);

        // Two loads in one slot: newest wins
        check_slot("s11", 3, 4'h1, 1'b1, 1, 16'h1111, 3, 16'h2222);
        slot("s12", 0, 4'h2, 1'b1);
        // Load on the wrap cycle bypasses into the very next slot
        check_slot("s13", 1, 4'h2, 1'b1, 6, 16'h5678, -1, 16'h0);

        bus.lz_blank = 1'b1;
        check_slot("s14", 2, 4'h6, 1'b1, 2, 16'h0045, -1, 16'h0);
        slot("s15", 3, 4'h0, 1'b0);
        slot("s16", 0, 4'h5, 1'b1);
        slot("s17", 1, 4'h4, 1'b1);
        slot("s18", 2, 4'h0, 1'b0);
        check_slot("s19", 3, 4'h0, 1'b0, 2, 16'h0000, -1, 16'h0);
        slot("s20", 0, 4'h0, 1'b1);
        check_slot("s21", 1, 4'h0, 1'b0, 2, 16'h9876, -1, 16'h0);
        bus.lz_blank = 1'b0;

        // Reset mid-slot at prescaler=5, index=2 (edge 181)
        repeat (5) edge_step();
        chk("pre_rst_an", 16'(bus.an), 16'h000B);
        chk("pre_rst_dig", 16'(bus.dig_val), 16'h0008);
        rst = 1'b1;
        #1;
        chk("async_rst_an", 16'(bus.an), 16'h000F);
        chk("async_rst_dig", 16'(bus.dig_val), 16'h0);
        chk("async_rst_ss", 16'(bus.slot_start), 16'h0);
        @(posedge clk);
        @(negedge clk);
        chk("hold_rst_an", 16'(bus.an), 16'h000F);
        chk("hold_rst_dig", 16'(bus.dig_val), 16'h0);
        rst = 1'b0;
        e   = 0;

        slot("r0", 0, 4'h0, 1'b1);
        slot("r1", 1, 4'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
